// File: rtl/prelude_pkg.sv
// Shared types and constants for the prelude CPU control unit.
// Opcodes, FSM states, register-file write-source selects and special register indices.
package prelude_pkg;

    typedef enum logic [1:0] {
        OP_LDI = 2'b00,
        OP_ALU = 2'b01,
        OP_CPY = 2'b10,
        OP_BR  = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_FETCH   = 2'd1,
        ST_EXEC    = 2'd2,
        ST_IO_WAIT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_IMM   = 2'd0,
        SEL_ALU   = 2'd1,
        SEL_REG_A = 2'd2,
        SEL_RIO   = 2'd3
    } rf_sel_e;

    localparam logic [2:0] REG_IO      = 3'd6;
    localparam logic [2:0] REG_ILL     = 3'd7;
    localparam logic [2:0] COND_ALWAYS = 3'b100;

    function automatic logic [7:0] pc_inc(input logic [7:0] pc);
        return pc + 8'd1;
    endfunction

endpackage

// File: rtl/prelude_decode.sv
// Purely combinational instruction decode: latched ir -> register-file, ALU and branch fields.
// The copy-specific flags let the sequencer handle rio handshakes and illegal indices.
module prelude_decode
    import prelude_pkg::*;
(
    input  logic [7:0] ir_i,
    output opcode_e    opcode_o,
    output logic [2:0] src_a_o,
    output logic [2:0] src_b_o,
    output logic [2:0] dst_o,
    output rf_sel_e    in_sel_o,
    output logic [7:0] imm_o,
    output logic [5:0] alu_op_o,
    output logic [2:0] cond_code_o,
    output logic       cpy_in_o,
    output logic       cpy_out_o,
    output logic       cpy_illegal_o,
    output logic       loop_cond_o
);

    logic [2:0] cpy_s;
    logic [2:0] cpy_d;

    assign cpy_s       = ir_i[5:3];
    assign cpy_d       = ir_i[2:0];
    assign opcode_o    = opcode_e'(ir_i[7:6]);
    assign imm_o       = {2'b00, ir_i[5:0]};
    assign alu_op_o    = ir_i[5:0];
    assign cond_code_o = ir_i[2:0];

    always_comb begin
        src_a_o  = 3'd0;
        src_b_o  = 3'd0;
        dst_o    = 3'd0;
        in_sel_o = SEL_IMM;
        case (opcode_o)
            OP_ALU: begin
                src_a_o  = 3'd1;
                src_b_o  = 3'd2;
                dst_o    = 3'd3;
                in_sel_o = SEL_ALU;
            end
            OP_CPY: begin
                src_a_o  = cpy_s;
                dst_o    = cpy_d;
                in_sel_o = (cpy_s == REG_IO) ? SEL_RIO : SEL_REG_A;
            end
            default: ;
        endcase
    end

    assign cpy_in_o      = (opcode_o == OP_CPY) && (cpy_s == REG_IO);
    assign cpy_out_o     = (opcode_o == OP_CPY) && (cpy_d == REG_IO);
    assign cpy_illegal_o = (opcode_o == OP_CPY) && ((cpy_s == REG_ILL) || (cpy_d == REG_ILL));
    assign loop_cond_o   = (opcode_o == OP_BR) && (ir_i[2:0] == COND_ALWAYS);

endmodule

// File: rtl/prelude_sequencer.sv
// Multi-cycle control unit for the prelude CPU: PC, instruction latch, run/step/halt
// debug control, self-loop halt detection and the rio valid/ready handshake.
//   state      | meaning
//   HALTED     | idle; waits for step or run (ignored once illegal is set)
//   FETCH      | latch ROM word at pc into ir
//   EXEC       | decode ir, strobe writes, update pc, retire
//   IO_WAIT    | copy stalled on rio; retried every cycle
module prelude_sequencer
    import prelude_pkg::*;
#(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic       RESET_RUN = 1'b1,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rom_data,
    input  logic             cond_true,
    input  logic [7:0]       r0_val,
    input  logic             ctl_run,
    input  logic             ctl_step,
    input  logic             ctl_halt,
    input  logic             io_in_valid,
    input  logic             io_out_ready,
    output logic [7:0]       pc,
    output logic [7:0]       ir,
    output logic [2:0]       rf_src_a,
    output logic [2:0]       rf_src_b,
    output logic [2:0]       rf_dst,
    output logic             rf_we,
    output logic [1:0]       rf_in_sel,
    output logic [7:0]       imm,
    output logic [5:0]       alu_op,
    output logic [2:0]       cond_code,
    output logic             io_in_ack,
    output logic             io_out_valid,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [7:0]       ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             step_q, step_d;

    opcode_e opcode;
    rf_sel_e in_sel;
    logic    cpy_in, cpy_out, cpy_illegal, loop_cond;
    logic    io_blocked, self_loop, complete, force_halt;

    prelude_decode u_decode (
        .ir_i          (ir_q),
        .opcode_o      (opcode),
        .src_a_o       (rf_src_a),
        .src_b_o       (rf_src_b),
        .dst_o         (rf_dst),
        .in_sel_o      (in_sel),
        .imm_o         (imm),
        .alu_op_o      (alu_op),
        .cond_code_o   (cond_code),
        .cpy_in_o      (cpy_in),
        .cpy_out_o     (cpy_out),
        .cpy_illegal_o (cpy_illegal),
        .loop_cond_o   (loop_cond)
    );

    assign io_blocked = (cpy_in && !io_in_valid) || (cpy_out && !io_out_ready);
    assign self_loop  = loop_cond && (r0_val == pc_q);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        retired_d    = retired_q;
        illegal_d    = illegal_q;
        step_d       = step_q;
        rf_we        = 1'b0;
        io_in_ack    = 1'b0;
        io_out_valid = 1'b0;
        complete     = 1'b0;
        force_halt   = 1'b0;

        case (state_q)
            ST_HALTED: begin
                if (!ctl_halt && !illegal_q) begin
                    if (ctl_step) begin
                        state_d = ST_FETCH;
                        step_d  = 1'b1;
                    end else if (ctl_run) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                ir_d    = rom_data;
                state_d = ST_EXEC;
            end
            ST_EXEC, ST_IO_WAIT: begin
                if (opcode == OP_CPY) begin
                    if (cpy_illegal) begin
                        illegal_d  = 1'b1;
                        pc_d       = pc_inc(pc_q);
                        complete   = 1'b1;
                        force_halt = 1'b1;
                    end else if (io_blocked) begin
                        state_d = ST_IO_WAIT;
                    end else begin
                        rf_we        = 1'b1;
                        io_in_ack    = cpy_in;
                        io_out_valid = cpy_out;
                        pc_d         = pc_inc(pc_q);
                        complete     = 1'b1;
                    end
                end else if (opcode == OP_BR) begin
                    complete = 1'b1;
                    if (self_loop) begin
                        force_halt = 1'b1;
                    end else if (cond_true) begin
                        pc_d = r0_val;
                    end else begin
                        pc_d = pc_inc(pc_q);
                    end
                end else begin
                    rf_we    = 1'b1;
                    pc_d     = pc_inc(pc_q);
                    complete = 1'b1;
                end
            end
            default: state_d = ST_HALTED;
        endcase

        // A pending halt or single-step only takes effect at the instruction boundary.
        if (complete) begin
            retired_d = retired_q + CNT_W'(1);
            step_d    = 1'b0;
            state_d   = (ctl_halt || step_q || !ctl_run || force_halt) ? ST_HALTED : ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_RUN ? ST_FETCH : ST_HALTED;
            pc_q      <= RESET_PC;
            ir_q      <= 8'h00;
            retired_q <= '0;
            illegal_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            step_q    <= step_d;
        end
    end

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign rf_in_sel = in_sel;
    assign halted    = (state_q == ST_HALTED);
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule
